fir_tap_mac_scheduler: RTL and testbench



---
 rtl/fir_tap_mac_scheduler.sv | 89 ++++++++
 tb/tb_fir_tap_mac_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_mac_scheduler.sv
// fir_tap_mac_scheduler: time-multiplexed FIR controller sharing one external multiplier across all taps
module fir_tap_mac_scheduler #(
    parameter int NTAPS  = 16,
    parameter int DATA_W = 16,
    parameter int COEF_W = 8,
    parameter int PROD_W = 24,
    parameter int ACC_W  = 28
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [DATA_W-1:0]   s_data,
    output logic signed [DATA_W-1:0]   mul_din0,
    output logic signed [COEF_W-1:0]   mul_din1,
    input  logic signed [PROD_W-1:0]   mul_dout,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [ACC_W-1:0]    m_data,
    output logic                       busy
);
    localparam int AW = $clog2(NTAPS);
    localparam bit FULL_RANGE = (NTAPS == (1 << AW));
    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                    state;
    logic signed [COEF_W-1:0]  coef [NTAPS];
    logic signed [DATA_W-1:0]  x [NTAPS];
    logic signed [ACC_W-1:0]   acc;
    logic [AW-1:0]             cnt;
    logic                      addr_ok;

    // Addresses beyond the last tap are dropped; with a power-of-two tap count every address is valid.
    assign addr_ok  = FULL_RANGE || (32'(coef_addr) < NTAPS);
    assign mul_din0 = (state == MAC) ? x[cnt] : '0;
    assign mul_din1 = (state == MAC) ? coef[cnt] : '0;
    assign m_data   = acc;

    // Sequencer: accept a sample, run one MAC per tap, then hold the result until taken.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= IDLE;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            busy    <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            for (int k = 0; k < NTAPS; k++) begin
                coef[k] <= '0;
                x[k]    <= '0;
            end
        end else begin
            if (state == IDLE && coef_we && addr_ok)
                coef[coef_addr] <= coef_data;
            case (state)
                IDLE: if (s_valid) begin
                    for (int k = NTAPS - 1; k > 0; k--)
                        x[k] <= x[k-1];
                    x[0]    <= s_data;
                    acc     <= '0;
                    cnt     <= '0;
                    s_ready <= 1'b0;
                    busy    <= 1'b1;
                    state   <= MAC;
                end
                MAC: begin
                    acc <= acc + ACC_W'(mul_dout);
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end
                end
                OUT: if (m_ready) begin
                    m_valid <= 1'b0;
                    busy    <= 1'b0;
                    s_ready <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_tap_mac_scheduler.sv
// tb_fir_tap_mac_scheduler: scoreboard bench for the shared-multiplier FIR controller
module tb_fir_tap_mac_scheduler;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               coef_we = 1'b0;
    logic [3:0]         coef_addr = '0;
    logic signed [7:0]  coef_data = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [15:0] s_data = '0;
    logic signed [15:0] mul_din0;
    logic signed [7:0]  mul_din1;
    logic signed [23:0] mul_dout;
    logic               m_valid;
    logic               m_ready = 1'b1;
    logic signed [27:0] m_data;
    logic               busy;

    logic               coef_we2 = 1'b0;
    logic [2:0]         coef_addr2 = '0;
    logic signed [7:0]  coef_data2 = '0;
    logic               s_valid2 = 1'b0;
    logic               s_ready2;
    logic signed [15:0] s_data2 = '0;
    logic signed [15:0] mul_din0_2;
    logic signed [7:0]  mul_din1_2;
    logic signed [23:0] mul_dout2;
    logic               m_valid2;
    logic               m_ready2 = 1'b1;
    logic signed [27:0] m_data2;
    logic               busy2;

    assign mul_dout  = 24'(mul_din0) * 24'(mul_din1);
    assign mul_dout2 = 24'(mul_din0_2) * 24'(mul_din1_2);

    fir_tap_mac_scheduler #(.NTAPS(N)) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
    );

    fir_tap_mac_scheduler #(.NTAPS(5)) dut5 (
        .ap_clk(clk), .ap_rst_n(rst_n), .coef_we(coef_we2), .coef_addr(coef_addr2),
        .coef_data(coef_data2), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .mul_din0(mul_din0_2), .mul_din1(mul_din1_2), .mul_dout(mul_dout2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .busy(busy2)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int mc [N];
    int mx [N];
    logic signed [27:0] q [$];

    function automatic logic signed [27:0] model_sum();
        longint s = 0;
        for (int k = 0; k < N; k++) s += longint'(mc[k]) * longint'(mx[k]);
        return 28'(s);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            mc[k] = 0;
            mx[k] = 0;
        end
        q.delete();
    endtask

    task automatic write_coef(input int a, input int v);
        logic signed [7:0] t;
        t = v[7:0];
        coef_we = 1'b1;
        coef_addr = a[3:0];
        coef_data = t;
        if (s_ready && a < N) mc[a] = int'(t);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic drive_sample(input logic signed [15:0] d);
        for (int t = 0; t < 200 && !s_ready; t++) @(negedge clk);
        if (!s_ready) begin
            total_cnt++;
            $display("FAIL accept_timeout s_ready=%b required=1", s_ready);
        end else begin
            s_valid = 1'b1;
            s_data = d;
            for (int k = N - 1; k > 0; k--) mx[k] = mx[k-1];
            mx[0] = int'(d);
            q.push_back(model_sum());
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic wait_out(output logic signed [27:0] d, output logic signed [27:0] e);
        for (int t = 0; t < 200 && !m_valid; t++) @(negedge clk);
        e = (q.size() > 0) ? q.pop_front() : 'x;
        if (!m_valid) begin
            total_cnt++;
            $display("FAIL out_timeout m_valid=%b required=1", m_valid);
            d = 'x;
        end else d = m_data;
        if (m_ready) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({s_ready, m_valid, busy} !== 3'b100) $display("FAIL reset_flags got=%b required=100", {s_ready, m_valid, busy});
        else pass_cnt++;
        total_cnt++;
        if (m_data !== 28'sd0) $display("FAIL reset_m_data got=%0d required=0", m_data);
        else pass_cnt++;
        total_cnt++;
        if ({mul_din0, mul_din1} !== 24'd0) $display("FAIL reset_mul got=%h required=0", {mul_din0, mul_din1});
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_impulse();
        logic signed [27:0] d, e;
        m_ready = 1'b1;
        for (int k = 0; k < N; k++) write_coef(k, k + 1);
        for (int i = 0; i < N + 1; i++) begin
            drive_sample((i == 0) ? 16'sd1 : 16'sd0);
            wait_out(d, e);
            total_cnt++;
            if (d !== e) $display("FAIL impulse_model[%0d] got=%0d required=%0d", i, d, e);
            else pass_cnt++;
            total_cnt++;
            if (d !== 28'((i < N) ? i + 1 : 0)) $display("FAIL impulse_value[%0d] got=%0d required=%0d", i, d, (i < N) ? i + 1 : 0);
            else pass_cnt++;
        end
    endtask

    task automatic test_extreme();
        logic signed [27:0] d, e;
        for (int k = 0; k < N; k++) write_coef(k, -128);
        for (int i = 0; i < N; i++) begin
            drive_sample(16'sh8000);
            wait_out(d, e);
            total_cnt++;
            if (d !== e) $display("FAIL extreme_model[%0d] got=%0d required=%0d", i, d, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (d !== 28'sd67108864) $display("FAIL extreme_max got=%0d required=67108864", d);
        else pass_cnt++;
        for (int k = 0; k < N; k++) write_coef(k, 127);
        drive_sample(16'sh8000);
        wait_out(d, e);
        total_cnt++;
        if (d !== -28'sd66584576 || d !== e) $display("FAIL extreme_mixed got=%0d required=-66584576", d);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic signed [27:0] d, e;
        int a0 = -1;
        int last_rise = -1;
        int rises = 0;
        logic prev_mv = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < N; k++) write_coef(k, int'($urandom_range(0, 255)));
        for (int c = 0; c < 89; c++) begin
            if (m_valid) begin
                total_cnt++;
                if (prev_mv) $display("FAIL tput_width cycle=%0d m_valid_prev=1 required=0", c);
                else pass_cnt++;
                e = (q.size() > 0) ? q.pop_front() : 'x;
                total_cnt++;
                if (m_data !== e) $display("FAIL tput_data cycle=%0d got=%0d required=%0d", c, m_data, e);
                else pass_cnt++;
                total_cnt++;
                if (last_rise < 0 ? (c - a0 != 17) : (c - last_rise != 18))
                    $display("FAIL tput_spacing cycle=%0d gap=%0d required=%0d", c, last_rise < 0 ? c - a0 : c - last_rise, last_rise < 0 ? 17 : 18);
                else pass_cnt++;
                last_rise = c;
                rises++;
            end
            prev_mv = m_valid;
            if (!(busy && !m_valid)) begin
                total_cnt++;
                if ({mul_din0, mul_din1} !== 24'd0) $display("FAIL mul_idle cycle=%0d got=%h required=0", c, {mul_din0, mul_din1});
                else pass_cnt++;
            end
            s_valid = 1'b1;
            s_data = 16'($urandom);
            if (s_ready) begin
                if (a0 < 0) a0 = c;
                for (int k = N - 1; k > 0; k--) mx[k] = mx[k-1];
                mx[0] = int'(s_data);
                q.push_back(model_sum());
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        total_cnt++;
        if (rises != 4) $display("FAIL tput_count got=%0d required=4", rises);
        else pass_cnt++;
        wait_out(d, e);
        total_cnt++;
        if (d !== e) $display("FAIL tput_drain got=%0d required=%0d", d, e);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic signed [27:0] d, e;
        m_ready = 1'b0;
        drive_sample(16'sd1234);
        wait_out(d, e);
        total_cnt++;
        if (d !== e) $display("FAIL bp_data got=%0d required=%0d", d, e);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({m_valid, s_ready, busy, m_data} !== {3'b101, d})
                $display("FAIL bp_hold[%0d] got=%b/%0d required=101/%0d", i, {m_valid, s_ready, busy}, m_data, d);
            else pass_cnt++;
        end
        m_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({m_valid, s_ready, busy} !== 3'b010) $display("FAIL bp_release got=%b required=010", {m_valid, s_ready, busy});
        else pass_cnt++;
    endtask

    task automatic test_coef_guards();
        logic signed [27:0] d, e;
        m_ready = 1'b1;
        write_coef(3, 20);
        drive_sample(16'sd300);
        coef_we = 1'b1;
        coef_addr = 4'd3;
        coef_data = 8'sd50;
        repeat (5) @(negedge clk);
        coef_we = 1'b0;
        wait_out(d, e);
        total_cnt++;
        if (d !== e) $display("FAIL guard_mac_write got=%0d required=%0d", d, e);
        else pass_cnt++;
        drive_sample(-16'sd700);
        wait_out(d, e);
        total_cnt++;
        if (d !== e) $display("FAIL guard_after got=%0d required=%0d", d, e);
        else pass_cnt++;
        coef_we = 1'b1;
        coef_addr = 4'd0;
        coef_data = -8'sd77;
        mc[0] = -77;
        drive_sample(-16'sd500);
        coef_we = 1'b0;
        wait_out(d, e);
        total_cnt++;
        if (d !== e) $display("FAIL guard_coincident got=%0d required=%0d", d, e);
        else pass_cnt++;
        m_ready2 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            coef_we2 = 1'b1;
            coef_addr2 = 3'(k);
            coef_data2 = (k < 5) ? 8'(k + 10) : 8'sd99;
            @(negedge clk);
        end
        coef_we2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_valid2 = 1'b1;
            s_data2 = (i == 0) ? 16'sd1 : 16'sd0;
            @(negedge clk);
            s_valid2 = 1'b0;
            for (int t = 0; t < 50 && !m_valid2; t++) @(negedge clk);
            total_cnt++;
            if (!m_valid2 || m_data2 !== 28'((i < 5) ? i + 10 : 0))
                $display("FAIL guard_addr5[%0d] got=%b/%0d required=1/%0d", i, m_valid2, m_data2, (i < 5) ? i + 10 : 0);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic signed [27:0] d, e;
        m_ready = 1'b1;
        drive_sample(16'sd5);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({m_valid, busy, s_ready} !== 3'b001) $display("FAIL rst_mid_flags got=%b required=001", {m_valid, busy, s_ready});
        else pass_cnt++;
        total_cnt++;
        if ({mul_din0, mul_din1, m_data} !== 52'd0) $display("FAIL rst_mid_data got=%h required=0", {mul_din0, mul_din1, m_data});
        else pass_cnt++;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            drive_sample((i == 0) ? 16'sd1 : 16'sd0);
            wait_out(d, e);
            total_cnt++;
            if (d !== e || d !== 28'sd0) $display("FAIL rst_mid_zero[%0d] got=%0d required=0", i, d);
            else pass_cnt++;
        end
        write_coef(0, 7);
        drive_sample(16'sd3);
        wait_out(d, e);
        total_cnt++;
        if (d !== e || d !== 28'sd21) $display("FAIL rst_mid_reload got=%0d required=21", d);
        else pass_cnt++;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_impulse();
        test_extreme();
        test_back_to_back();
        test_backpressure();
        test_coef_guards();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
